// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the dual-lane data-memory port arbiter.
package dmem_port_arbiter_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_CW = 16;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVE_B = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// CW-bit saturating event counter with synchronous active-low clear.
// Latency: count visible the cycle after inc_i; no backpressure.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          clr_n_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Puts lanes A (older) and B onto one memory port; dual requests stall one cycle and go A then B.
// Single access has zero added latency; optional DMEM_ARB_COALESCE_EN merges same-address dual stores.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] conflict_cnt
);

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic [DW-1:0] a_rdata_q;
    logic          lane_sel;
    logic          cap_a;
    logic          cnt_inc;
    logic          coalesce;

    // Two stores to one address: only the younger (B) value is architecturally visible.
`ifdef DMEM_ARB_COALESCE_EN
    assign coalesce = a_we & b_we & (a_addr == b_addr);
`else
    assign coalesce = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        lane_sel = LANE_A;
        mem_we   = 1'b0;
        stall    = 1'b0;
        a_rdata  = '0;
        b_rdata  = '0;
        cap_a    = 1'b0;
        cnt_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_req && b_req) begin
                    if (coalesce) begin
                        lane_sel = LANE_B;
                        mem_we   = b_we;
                        b_rdata  = mem_rdata;
                    end else begin
                        lane_sel = LANE_A;
                        mem_we   = a_we;
                        a_rdata  = mem_rdata;
                        stall    = 1'b1;
                        cap_a    = 1'b1;
                        cnt_inc  = 1'b1;
                        state_d  = SERVE_B;
                    end
                end else if (a_req) begin
                    lane_sel = LANE_A;
                    mem_we   = a_we;
                    a_rdata  = mem_rdata;
                end else if (b_req) begin
                    lane_sel = LANE_B;
                    mem_we   = b_we;
                    b_rdata  = mem_rdata;
                end
            end
            SERVE_B: begin
                // Lane inputs are held by the stall, so b_req need not be re-checked.
                lane_sel = LANE_B;
                mem_we   = b_we;
                a_rdata  = a_rdata_q;
                b_rdata  = mem_rdata;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!rst) begin
            mem_we  = 1'b0;
            stall   = 1'b0;
            a_rdata = '0;
            b_rdata = '0;
            cap_a   = 1'b0;
            cnt_inc = 1'b0;
        end
    end

    assign mem_addr  = (lane_sel == LANE_B) ? b_addr  : a_addr;
    assign mem_wdata = (lane_sel == LANE_B) ? b_wdata : a_wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (cap_a) begin
                a_rdata_q <= mem_rdata;
            end
        end
    end

    sat_counter #(
        .CW (CW)
    ) u_conflict_cnt (
        .clk     (clk),
        .clr_n_i (rst),
        .inc_i   (cnt_inc),
        .cnt_o   (conflict_cnt)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-addressed memory model.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          stall, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] conflict_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    logic [DW-1:0] mem [0:63] = '{default: '0};

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    dmem_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .b_req        (b_req),
        .b_we         (b_we),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .a_rdata      (a_rdata),
        .b_rdata      (b_rdata),
        .stall        (stall),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct {
        logic        a_req;
        logic        a_we;
        logic [31:0] a_addr;
        logic [31:0] a_wdata;
        logic        b_req;
        logic        b_we;
        logic [31:0] b_addr;
        logic [31:0] b_wdata;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_ard;
        logic [31:0] e_brd;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_lanes(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                             input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic go_idle();
        set_lanes(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           ar    aw    a_addr  a_wdata       br    bw    b_addr  b_wdata       we    addr    wdata         ard           brd
        vt[0] = '{1'b0, 1'b0, 32'h10, 32'h0000_1234, 1'b0, 1'b0, 32'h14, 32'h0000_5678, 1'b0, 32'h10, 32'h0000_1234, 32'h0,        32'h0};
        vt[1] = '{1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h14, 32'h0,        1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0,        32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h14, 32'h0,        1'b0, 32'h10, 32'h0,        32'hDEAD_BEEF, 32'h0};
        vt[3] = '{1'b0, 1'b0, 32'h18, 32'h0,        1'b1, 1'b1, 32'h14, 32'hCAFE_F00D, 1'b1, 32'h14, 32'hCAFE_F00D, 32'h0,        32'h0};
        vt[4] = '{1'b0, 1'b0, 32'h18, 32'h0,        1'b1, 1'b0, 32'h14, 32'h0,        1'b0, 32'h14, 32'h0,        32'h0,        32'hCAFE_F00D};
        vt[5] = '{1'b1, 1'b0, 32'h14, 32'h0,        1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'h14, 32'h0,        32'hCAFE_F00D, 32'h0};
        vt[6] = '{1'b1, 1'b1, 32'h20, 32'h11,       1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h20, 32'h11,       32'h0,        32'h0};
        vt[7] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h24, 32'h22,       1'b1, 32'h24, 32'h22,       32'h0,        32'h0};
        vt[8] = '{1'b1, 1'b0, 32'h60, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h60, 32'h0,        32'hA0,       32'h0};
        vt[9] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h64, 32'h0,        1'b0, 32'h64, 32'h0,        32'h0,        32'hB0};

        // Reset held with both lanes writing: port must stay quiet.
        rst = 1'b0;
        set_lanes(1'b1, 1'b1, 32'h60, 32'hA0, 1'b1, 1'b1, 32'h64, 32'hB0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_stall", {31'b0, stall}, 32'h0);
            chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
            chk("rst_a_rdata", a_rdata, 32'h0);
            chk("rst_b_rdata", b_rdata, 32'h0);
            next_cycle();
        end
        chk("rst_cnt", {28'b0, conflict_cnt}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_stall", {31'b0, stall}, 32'h1);
        chk("rel_addr_a", mem_addr, 32'h60);
        next_cycle();
        exp_cnt = 1;
        @(negedge clk);
        chk("rel_serve_b_stall", {31'b0, stall}, 32'h0);
        chk("rel_serve_b_addr", mem_addr, 32'h64);
        chk("rel_serve_b_we", {31'b0, mem_we}, 32'h1);
        next_cycle();
        go_idle();
        chk("rel_cnt", {28'b0, conflict_cnt}, exp_cnt);

        // Single-lane / idle vectors.
        for (int i = 0; i < 10; i++) begin
            set_lanes(vt[i].a_req, vt[i].a_we, vt[i].a_addr, vt[i].a_wdata,
                      vt[i].b_req, vt[i].b_we, vt[i].b_addr, vt[i].b_wdata);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, 32'h0);
            chk($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, vt[i].e_we});
            chk($sformatf("v%0d_addr", i), mem_addr, vt[i].e_addr);
            if (vt[i].e_we) chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].e_wdata);
            chk($sformatf("v%0d_ard", i), a_rdata, vt[i].e_ard);
            chk($sformatf("v%0d_brd", i), b_rdata, vt[i].e_brd);
            next_cycle();
        end
        go_idle();

        // Dual read: A then B, one stall cycle.
        set_lanes(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
        @(negedge clk);
        chk("dual_c1_stall", {31'b0, stall}, 32'h1);
        chk("dual_c1_addr", mem_addr, 32'h20);
        next_cycle();
        exp_cnt++;
        @(negedge clk);
        chk("dual_c2_stall", {31'b0, stall}, 32'h0);
        chk("dual_c2_addr", mem_addr, 32'h24);
        chk("dual_c2_ard", a_rdata, 32'h11);
        chk("dual_c2_brd", b_rdata, 32'h22);
        next_cycle();
        go_idle();
        chk("dual_cnt", {28'b0, conflict_cnt}, exp_cnt);

        // Program order: B's read sees A's same-cycle write.
        set_lanes(1'b1, 1'b1, 32'h30, 32'h55, 1'b1, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        chk("ord_c1_stall", {31'b0, stall}, 32'h1);
        chk("ord_c1_we", {31'b0, mem_we}, 32'h1);
        next_cycle();
        exp_cnt++;
        @(negedge clk);
        chk("ord_c2_we", {31'b0, mem_we}, 32'h0);
        chk("ord_c2_brd", b_rdata, 32'h55);
        next_cycle();
        go_idle();

        // Reset during SERVE_B drops lane B's store.
        set_lanes(1'b1, 1'b1, 32'h44, 32'h77, 1'b1, 1'b1, 32'h40, 32'h99);
        @(negedge clk);
        chk("abort_c1_stall", {31'b0, stall}, 32'h1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_we", {31'b0, mem_we}, 32'h0);
        next_cycle();
        rst = 1'b1;
        exp_cnt = 0;
        set_lanes(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        chk("abort_idle_addr", mem_addr, 32'h40);
        chk("abort_no_write", a_rdata, 32'h0);
        chk("abort_idle_stall", {31'b0, stall}, 32'h0);
        next_cycle();
        a_addr = 32'h44;
        @(negedge clk);
        chk("abort_a_kept", a_rdata, 32'h77);
        chk("abort_cnt", {28'b0, conflict_cnt}, exp_cnt);
        next_cycle();
        go_idle();

        // Two stores to the same address.
        set_lanes(1'b1, 1'b1, 32'h50, 32'h1, 1'b1, 1'b1, 32'h50, 32'h2);
        @(negedge clk);
`ifdef DMEM_ARB_COALESCE_EN
        chk("coal_stall", {31'b0, stall}, 32'h0);
        chk("coal_wdata", mem_wdata, 32'h2);
        next_cycle();
`else
        chk("coal_c1_stall", {31'b0, stall}, 32'h1);
        chk("coal_c1_wdata", mem_wdata, 32'h1);
        next_cycle();
        exp_cnt++;
        @(negedge clk);
        chk("coal_c2_wdata", mem_wdata, 32'h2);
        next_cycle();
`endif
        set_lanes(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("coal_final", a_rdata, 32'h2);
        chk("coal_cnt", {28'b0, conflict_cnt}, exp_cnt);
        next_cycle();
        go_idle();

        // Drive the counter into saturation and past it.
        for (int k = 0; k < 18; k++) begin
            set_lanes(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
            next_cycle();
            next_cycle();
            go_idle();
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            chk($sformatf("sat_%0d", k), {28'b0, conflict_cnt}, exp_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Sequences the two-lane dual-issue core's data-memory traffic onto a single-port data memory. Lane A is always older in program order than lane B. When both lanes request in the same cycle, the arbiter stalls the pipeline for one cycle and serves A, then B, preserving program order. It returns per-lane read data and counts conflict stalls.

Parameters:
AW, 32, byte address width
DW, 32, data width
CW, 16, conflict counter width (saturating)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
a_req  input  1  lane A memory access valid
a_we  input  1  lane A write (1) / read (0)
a_addr  input  AW  lane A byte address
a_wdata  input  DW  lane A write data
b_req  input  1  lane B memory access valid
b_we  input  1  lane B write / read
b_addr  input  AW  lane B byte address
b_wdata  input  DW  lane B write data
a_rdata  output  DW  lane A read data
b_rdata  output  DW  lane B read data
stall  output  1  hold both lanes; inputs must stay stable while 1
mem_we  output  1  memory write enable (write at clk rising edge)
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, combinational from mem_addr
conflict_cnt  output  CW  number of dual-request stall cycles, saturating

Behaviour:
- Reset: one clock, synchronous, active-low. At a rising clk edge with rst=0: state becomes IDLE, a_rdata_q=0, conflict_cnt=0. While rst=0, outputs are forced to mem_we=0, stall=0, a_rdata=0 and b_rdata=0.
- FSM states: IDLE, SERVE_B. The memory-port outputs are combinational from state and inputs.
- IDLE, no request: mem_we=0, mem_addr=a_addr, mem_wdata=a_wdata, stall=0.
- IDLE, only a_req: mem_* driven from lane A; a_rdata=mem_rdata; stall=0. Zero added latency.
- IDLE, only b_req: mem_* driven from lane B; b_rdata=mem_rdata; stall=0.
- IDLE, a_req and b_req:
  - mem_* driven from lane A; stall=1.
  - At the clock edge: a_rdata_q<=mem_rdata, and conflict_cnt increments unless it is at all-ones.
  - Next state is SERVE_B.
- SERVE_B:
  - mem_* driven from lane B, regardless of b_req, because inputs are held.
  - stall=0; a_rdata=a_rdata_q; b_rdata=mem_rdata.
  - Next state is IDLE.
- A B read of an address A wrote in the preceding cycle returns A's data, because the memory write has committed by SERVE_B.
- a_rdata and b_rdata are 0 whenever that lane is not served in the current cycle, except a_rdata in SERVE_B.
- Reset asserted during SERVE_B aborts lane B's access: no write occurs and state returns to IDLE.
- conflict_cnt saturates at 2^CW-1 and never wraps.
- Addresses pass through unmodified; alignment is the memory's concern.

Optional Feature:
DMEM_ARB_COALESCE_EN.
- Defined: in IDLE, if both lanes request, a_we=b_we=1 and a_addr==b_addr, a single-cycle B write is issued. A's write is dropped (dead store), stall=0, the FSM stays in IDLE and conflict_cnt is not incremented.
- Undefined: this case follows the normal two-cycle A-then-B sequence.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SERVE_B);
  - lane select constants (LANE_A=0, LANE_B=1);
  - the default widths.
- One natural sub-module, sat_counter: a CW-bit saturating counter with synchronous active-low clear and inc enable, used for conflict_cnt.
- The port mux stays inline.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with a_req=b_req=1 -> stall=0, mem_we=0, conflict_cnt=0; the cycle after rst=1 -> stall=1.
2. Single lane: a_req=1, a_we=1, a_addr=0x10, a_wdata=0xDEADBEEF; next cycle a_req=1, a_we=0, a_addr=0x10 -> a_rdata=0xDEADBEEF, stall never 1.
3. Dual read: mem holds 0x11 at 0x20 and 0x22 at 0x24; a and b read these -> cycle1 stall=1, mem_addr=0x20; cycle2 stall=0, mem_addr=0x24, a_rdata=0x11, b_rdata=0x22; conflict_cnt=1.
4. Ordering: A writes 0x55 to 0x30, B reads 0x30 in the same cycle -> b_rdata=0x55 in cycle 2.
5. Reset mid-op: dual write with B to 0x40 (old value 0x0), rst=0 during SERVE_B -> 0x40 still reads 0x0, state IDLE.
6. Coalesce (DMEM_ARB_COALESCE_EN defined):
   - A writes 0x1 and B writes 0x2, both to 0x50 -> single cycle, stall=0, 0x50 reads 0x2, conflict_cnt unchanged.
   - Without the macro -> 2 cycles, same final value, conflict_cnt+1.
   - Also check saturation: force the counter to all-ones, then a conflict -> it stays all-ones.
